wb_daq_sram: RTL and testbench
==============================

Name: wb_daq_sram

Overview:
- Wishbone B3 slave SRAM that sits directly downstream of the DAQ bus master.
- Sinks the sample words that the master writes to per-channel buffer addresses.
- Supports classic and incrementing-burst (linear/wrap4/8/16) cycles with byte selects.
- Provides read-back for software and a write-beat counter for DAQ throughput checks.

Parameters:
- aw, 32, Wishbone address width (byte address).
- dw, 32, data width; fixed at 32 (4 byte lanes).
- depth_log2, 10, log2 of the number of 32-bit words (1024 words = 4 KB).
- base_addr, 32'h0000_0000, byte base address; must be aligned to 4*2^depth_log2.

Ports:
- wb_clk  in  1  clock; all logic on the rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- wb_adr_i  in  aw  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte-lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; others treated as 000.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  beat acknowledge.
- wb_err_o  out  1  error; address out of range.
- wb_rty_o  out  1  tied 0.
- clear_count  in  1  synchronous clear of write_count.
- write_count  out  16  committed write beats, saturating.

Behaviour:
- Reset, asynchronous on wb_rst_n low: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, write_count=0, FSM to IDLE. Memory contents are not reset.
- Reset asserted mid-burst: outputs drop in the same cycle. After release the FSM restarts from IDLE and ignores the in-flight cycle until stb is seen with ack low.
- In range means base_addr <= adr < base_addr + 4*2^depth_log2. Word index = adr[depth_log2+1:2].
- FSM states:
  - IDLE: on cyc&stb, in range, cti=010 -> BURST. In range, other cti -> CLASSIC. Out of range -> ERR.
  - CLASSIC: ack=1 for exactly one cycle -> IDLE. At least one dead cycle before the next accept, so a back-to-back classic ack pattern is 1,0,1,0.
  - BURST: ack=1 every cycle while cyc&stb. Leave -> IDLE on the acked beat where cti=111, or immediately when cyc or stb drops (ack deasserted that cycle).
  - ERR: err=1 for one cycle, no ack, no write -> IDLE.
- Latency: first ack/err one cycle after stb is sampled with ack low. Burst beats follow at one per cycle.
- Writes:
  - Commit on a cycle with ack=1 & we=1, using the wb_adr_i, wb_dat_i and wb_sel_i present in that cycle.
  - Lane k written only if sel[k]. sel=0000 still acks and still counts.
- Reads:
  - wb_dat_o is valid whenever ack=1.
  - First beat is registered from the stb address.
  - Later burst beats read from an internal next-address: linear = idx+1, wrapping at the top of memory to index 0. wrapN = idx[hi:0]+1 within the aligned N-word block, upper bits held.
  - A burst that runs onto an out-of-range address mid-burst: err=1 for that beat instead of ack, burst terminates -> IDLE.
- Simultaneous read of a word being written in the same burst returns the old data (read-before-write).
- write_count increments by 1 per committed write beat and saturates at 16'hFFFF.
  - clear_count sets it to 0 next cycle.
  - clear_count has priority over a same-cycle increment.
- Non-burst cti codes with we=0 or 1 behave as classic.

Test Plan:
- Reset: wb_rst_n low mid-burst -> ack, err and write_count go to 0 at once. After release, a classic read of word 0 returns the previously written value.
- Classic write 32'hDEAD_BEEF, sel=1111 to base+0x10, then classic read -> ack one cycle after stb each time, read data 32'hDEAD_BEEF, write_count=1.
- Byte lanes: write 32'h1122_3344 with sel=1111, then 32'hAABB_CCDD with sel=0101 -> readback 32'h11BB_33DD.
- Linear burst write of 8 beats (cti=010 x7, then 111) from base+0x00, data 0..7 -> 8 consecutive acks, then ack=0. write_count=8. A wrap4 read burst from base+0x08 returns words 2,3,0,1.
- Address base + 4*2^depth_log2 -> err=1 one cycle after stb, ack never high, memory and write_count unchanged.
- Saturation: preload write_count to FFFF, then one write -> stays FFFF. Assert clear_count in the same cycle as a write -> write_count=0.

Source files
------------

// File: rtl/wb_daq_sram.sv
`timescale 1ns/1ps
// Wishbone B3 slave SRAM that sinks DAQ sample words. It supports classic and incrementing
// bursts with byte selects, registered read data and a saturating write-beat counter.
module wb_daq_sram #(
    parameter int            aw         = 32,
    parameter int            dw         = 32,
    parameter int            depth_log2 = 10,
    parameter logic [aw-1:0] base_addr  = '0
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic [aw-1:0]     wb_adr_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [dw/8-1:0]   wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [dw-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    input  logic              clear_count,
    output logic [15:0]       write_count
);

    typedef enum logic [1:0] {S_IDLE, S_CLASSIC, S_BURST, S_ERR} state_t;
    typedef logic [depth_log2-1:0] idx_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [dw-1:0] r_mem [0:(1<<depth_log2)-1];
    logic [dw-1:0] r_dat;
    idx_t          r_nextIdx;
    logic [15:0]   r_count;
    idx_t          w_idx;
    logic          w_req;
    logic          w_inRange;
    logic          w_isBurst;
    logic          w_isEnd;
    logic          w_ack;
    logic          w_err;
    logic          w_accept;
    logic          w_unused;

    // Base is aligned to the memory size, so the range check reduces to an upper-bit compare.
    assign w_inRange = (wb_adr_i[aw-1:depth_log2+2] == base_addr[aw-1:depth_log2+2]);
    assign w_idx     = wb_adr_i[depth_log2+1:2];
    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_isBurst = (wb_cti_i == 3'b010);
    assign w_isEnd   = (wb_cti_i == 3'b111);
    assign w_unused  = ^wb_adr_i[1:0];

    function automatic idx_t nextIdx(input idx_t i, input logic [1:0] bte);
        idx_t mask;
        case (bte)
            2'b01:   mask = idx_t'(3);
            2'b10:   mask = idx_t'(7);
            2'b11:   mask = idx_t'(15);
            default: mask = '0;
        endcase
        if (bte == 2'b00)
            return i + idx_t'(1);
        return (i & ~mask) | ((i + idx_t'(1)) & mask);
    endfunction

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (!w_inRange)
                        w_nextState = S_ERR;
                    else if (w_isBurst)
                        w_nextState = S_BURST;
                    else
                        w_nextState = S_CLASSIC;
                end
            end
            S_CLASSIC: begin
                w_ack       = 1'b1;
                w_nextState = S_IDLE;
            end
            S_BURST: begin
                if (!w_req) begin
                    w_nextState = S_IDLE;
                end else if (!w_inRange) begin
                    w_err       = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_ack = 1'b1;
                    if (w_isEnd)
                        w_nextState = S_IDLE;
                end
            end
            S_ERR: begin
                w_err       = 1'b1;
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && w_req && w_inRange;

    // The first beat reads the strobed address; later burst beats run from the prefetched index.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_dat     <= '0;
            r_nextIdx <= '0;
        end else if (w_accept) begin
            r_dat     <= r_mem[w_idx];
            r_nextIdx <= nextIdx(w_idx, wb_bte_i);
        end else if ((r_state == S_BURST) && w_ack) begin
            r_dat     <= r_mem[r_nextIdx];
            r_nextIdx <= nextIdx(r_nextIdx, wb_bte_i);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (w_ack && wb_we_i) begin
            for (int k = 0; k < dw/8; k++) begin
                if (wb_sel_i[k])
                    r_mem[w_idx][8*k +: 8] <= wb_dat_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
            r_count <= '0;
        else if (clear_count)
            r_count <= '0;
        else if (w_ack && wb_we_i && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;
    end

    assign wb_dat_o    = r_dat;
    assign wb_ack_o    = w_ack;
    assign wb_err_o    = w_err;
    assign wb_rty_o    = 1'b0;
    assign write_count = r_count;

endmodule

// File: tb/tb_wb_daq_sram.sv
`timescale 1ns/1ps
// Self-checking bench for wb_daq_sram. It combines a table of classic vectors and burst
// sequences with randomized classic traffic that is checked against a word-array reference model.
module tb_wb_daq_sram;
    localparam int DL    = 10;
    localparam int WORDS = 1 << DL;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] adr   = '0;
    logic [31:0] datI  = '0;
    logic [3:0]  sel   = '0;
    logic        we    = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic [2:0]  cti   = '0;
    logic [1:0]  bte   = '0;
    logic        clr   = 1'b0;
    logic [31:0] datO;
    logic        ack, err, rty;
    logic [15:0] wcount;

    always #5 clk = ~clk;

    wb_daq_sram #(.aw(32), .dw(32), .depth_log2(DL), .base_addr(32'h0)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(datI), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(datO), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
        .clear_count(clr), .write_count(wcount)
    );

    int vecCount  = 0;
    int missCount = 0;

    logic [31:0] refMem [WORDS];
    bit          refKnown [WORDS];
    int          refCount = 0;

    logic [31:0] burstRead [$];
    int burstAcks, burstErrs, burstFirst, burstLast;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        expAck;
        logic        expErr;
        logic        chkRead;
        logic [31:0] expRead;
        logic [15:0] expCount;
    } vec_t;
    vec_t tbl [11];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dropBus();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        cti = 3'b000;
    endtask

    // Reference: a plain word array with lane merge and a saturating beat counter.
    function automatic void refWrite(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) refMem[w][8*k +: 8] = d[8*k +: 8];
        if (s == 4'hF) refKnown[w] = 1'b1;
        if (refCount < 65535) refCount++;
    endfunction

    function automatic logic [31:0] beatAddr(input logic [31:0] start, input int i, input logic [1:0] b);
        int w0, n, blk;
        w0 = int'(start >> 2);
        if (b == 2'b00) return 32'((w0 + i) * 4);
        n   = 2 << b;
        blk = w0 - (w0 % n);
        return 32'((blk + ((w0 % n) + i) % n) * 4);
    endfunction

    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, output logic gotAck, output logic gotErr,
                                 output logic [31:0] rd);
        tick();
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; datI = d; sel = s; cti = 3'b000;
        @(negedge clk);
        checkOutput("accept-cycle-quiet", {30'b0, ack, err}, 32'h0);
        tick();
        @(negedge clk);
        gotAck = ack;
        gotErr = err;
        rd     = datO;
        tick();
        dropBus();
    endtask

    task automatic checkedClassic(input string name, input bit w, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] s);
        logic gA, gE;
        logic [31:0] rd, expD;
        bit inR, known;
        int wi;
        inR   = (a < 32'(WORDS * 4));
        wi    = int'(a[DL+1:2]);
        expD  = refMem[wi];
        known = refKnown[wi];
        applyStimulus(w, a, d, s, gA, gE, rd);
        checkOutput({name, "-ack"}, {31'b0, gA}, {31'b0, inR});
        checkOutput({name, "-err"}, {31'b0, gE}, {31'b0, !inR});
        if (!w && inR && known) checkOutput({name, "-rdata"}, rd, expD);
        if (w && inR) refWrite(wi, d, s);
        checkOutput({name, "-count"}, {16'b0, wcount}, 32'(refCount));
    endtask

    task automatic runBurst(input bit w, input logic [31:0] start, input int n,
                            input logic [1:0] b, input logic [31:0] dataBase);
        int beat = 0;
        burstRead.delete();
        burstAcks = 0; burstErrs = 0; burstFirst = -1; burstLast = -1;
        tick();
        cyc = 1'b1; stb = 1'b1; we = w; bte = b; sel = 4'hF;
        adr = beatAddr(start, 0, b); datI = dataBase;
        cti = (n == 1) ? 3'b111 : 3'b010;
        for (int c = 0; c < n + 8 && beat < n; c++) begin
            @(negedge clk);
            if (ack) begin
                burstAcks++;
                burstRead.push_back(datO);
                if (burstFirst < 0) burstFirst = c;
                burstLast = c;
                beat++;
                tick();
                if (beat < n) begin
                    adr  = beatAddr(start, beat, b);
                    datI = dataBase + 32'(beat);
                    cti  = (beat == n - 1) ? 3'b111 : 3'b010;
                end else begin
                    dropBus();
                end
            end else if (err) begin
                burstErrs++;
                beat = n;
                tick();
                dropBus();
            end else begin
                tick();
            end
        end
        if (beat < n) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL burst-timeout: got %0d beats, expected %0d", beat, n);
            dropBus();
        end
    endtask

    task automatic clearCount();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        refCount = 0;
    endtask

    initial begin
        logic gA, gE;
        logic [31:0] rd;
        logic [3:0] pattern;
        logic [31:0] wrapExp [4];

        tbl[0]  = '{1'b1, 32'h10,       32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          16'd1};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 16'd1};
        tbl[2]  = '{1'b1, 32'h20,       32'h1122_3344, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          16'd2};
        tbl[3]  = '{1'b1, 32'h20,       32'hAABB_CCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0,          16'd3};
        tbl[4]  = '{1'b0, 32'h20,       32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'h11BB_33DD, 16'd3};
        tbl[5]  = '{1'b1, 32'h00,       32'h600D_600D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          16'd4};
        tbl[6]  = '{1'b1, 32'h1000,     32'h1234_5678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,          16'd4};
        tbl[7]  = '{1'b0, 32'h00,       32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'h600D_600D, 16'd4};
        tbl[8]  = '{1'b0, 32'hFFFF_FFF0, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0,          16'd4};
        tbl[9]  = '{1'b1, 32'h13,       32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0,          16'd5};
        tbl[10] = '{1'b0, 32'h10,       32'h0,         4'hF, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D, 16'd5};

        for (int i = 0; i < WORDS; i++) begin
            refMem[i]   = '0;
            refKnown[i] = 1'b0;
        end

        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset-ack",   {31'b0, ack}, 32'h0);
        checkOutput("reset-err",   {31'b0, err}, 32'h0);
        checkOutput("reset-rty",   {31'b0, rty}, 32'h0);
        checkOutput("reset-dat",   datO, 32'h0);
        checkOutput("reset-count", {16'b0, wcount}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] classic vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, gA, gE, rd);
            checkOutput($sformatf("tbl%0d-ack", i), {31'b0, gA}, {31'b0, tbl[i].expAck});
            checkOutput($sformatf("tbl%0d-err", i), {31'b0, gE}, {31'b0, tbl[i].expErr});
            if (tbl[i].chkRead) checkOutput($sformatf("tbl%0d-rdata", i), rd, tbl[i].expRead);
            checkOutput($sformatf("tbl%0d-count", i), {16'b0, wcount}, {16'b0, tbl[i].expCount});
            if (tbl[i].we && tbl[i].expAck) refWrite(int'(tbl[i].adr[DL+1:2]), tbl[i].dat, tbl[i].sel);
        end

        $display("[TB] linear burst write of 8 beats");
        clearCount();
        runBurst(1'b1, 32'h0, 8, 2'b00, 32'h0);
        for (int i = 0; i < 8; i++) refWrite(i, 32'(i), 4'hF);
        checkOutput("burst8-acks", 32'(burstAcks), 32'd8);
        checkOutput("burst8-first", 32'(burstFirst), 32'd1);
        checkOutput("burst8-consecutive", 32'(burstLast - burstFirst + 1), 32'd8);
        @(negedge clk);
        checkOutput("burst8-ack-after", {31'b0, ack}, 32'h0);
        checkOutput("burst8-count", {16'b0, wcount}, 32'd8);

        $display("[TB] wrap4 read burst from 0x08");
        wrapExp = '{32'd2, 32'd3, 32'd0, 32'd1};
        runBurst(1'b0, 32'h08, 4, 2'b01, 32'h0);
        checkOutput("wrap4-acks", 32'(burstAcks), 32'd4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("wrap4-beat%0d", k),
                        (k < burstRead.size()) ? burstRead[k] : 32'hFFFF_FFFF, wrapExp[k]);
        checkOutput("wrap4-count", {16'b0, wcount}, 32'd8);

        $display("[TB] back-to-back classic reads");
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF; cti = 3'b000; bte = 2'b00;
        pattern = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pattern = {pattern[2:0], ack};
            if (ack) checkOutput($sformatf("b2b-rdata%0d", c), datO, refMem[4]);
            tick();
        end
        dropBus();
        checkOutput("b2b-ack-pattern", {28'b0, pattern}, 32'h5);

        $display("[TB] linear burst running past the top of memory");
        runBurst(1'b1, 32'(WORDS * 4 - 8), 4, 2'b00, 32'hA000_0000);
        refWrite(WORDS - 2, 32'hA000_0000, 4'hF);
        refWrite(WORDS - 1, 32'hA000_0001, 4'hF);
        checkOutput("top-acks", 32'(burstAcks), 32'd2);
        checkOutput("top-errs", 32'(burstErrs), 32'd1);
        checkOutput("top-count", {16'b0, wcount}, 32'(refCount));
        checkedClassic("top-read", 1'b0, 32'(WORDS * 4 - 4), 32'h0, 4'hF);

        $display("[TB] randomized classic traffic");
        runBurst(1'b1, 32'h0, 32, 2'b00, 32'hC0DE_0000);
        for (int i = 0; i < 32; i++) refWrite(i, 32'hC0DE_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            else
                a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            checkedClassic("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("[TB] reset asserted mid-burst");
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00; sel = 4'hF;
        adr = 32'h40; datI = 32'h5555_0000;
        @(negedge clk);
        tick();
        @(negedge clk);
        checkOutput("rst-beat0-ack", {31'b0, ack}, 32'h1);
        tick();
        refWrite(16, 32'h5555_0000, 4'hF);
        adr = 32'h44; datI = 32'h5555_0001;
        @(negedge clk);
        checkOutput("rst-beat1-ack", {31'b0, ack}, 32'h1);
        rst_n = 1'b0;
        #1;
        refCount = 0;
        checkOutput("rst-mid-ack",   {31'b0, ack}, 32'h0);
        checkOutput("rst-mid-err",   {31'b0, err}, 32'h0);
        checkOutput("rst-mid-count", {16'b0, wcount}, 32'h0);
        dropBus();
        @(negedge clk);
        rst_n = 1'b1;
        checkedClassic("rst-read0", 1'b0, 32'h0, 32'h0, 4'hF);
        checkedClassic("rst-read16", 1'b0, 32'h40, 32'h0, 4'hF);
        checkedClassic("rst-read17", 1'b0, 32'h44, 32'h0, 4'hF);

        $display("[TB] counter saturation and clear priority");
        clearCount();
        runBurst(1'b1, 32'h0, 65535, 2'b11, 32'h0);
        for (int i = 0; i < 65535; i++) refWrite(i % 16, 32'(i), 4'hF);
        checkOutput("sat-reach", {16'b0, wcount}, 32'h0000_FFFF);
        checkedClassic("sat-hold", 1'b1, 32'h80, 32'h0BAD_CAFE, 4'hF);
        checkOutput("sat-hold-literal", {16'b0, wcount}, 32'h0000_FFFF);
        clr = 1'b1;
        applyStimulus(1'b1, 32'h84, 32'h7777_8888, 4'hF, gA, gE, rd);
        clr = 1'b0;
        refWrite(33, 32'h7777_8888, 4'hF);
        refCount = 0;
        checkOutput("clear-prio-ack", {31'b0, gA}, 32'h1);
        checkOutput("clear-prio-count", {16'b0, wcount}, 32'h0);
        checkedClassic("clear-readback", 1'b0, 32'h84, 32'h0, 4'hF);
        checkedClassic("sat-wrap-read", 1'b0, 32'h3C, 32'h0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
